// File: rtl/mips32_seq_mul.sv
// mips32_seq_mul: multi-cycle shift-add multiplier with start/done handshake and flush abort
module mips32_seq_mul #(
  parameter int WIDTH        = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int SIGNED_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N  = WIDTH / BITS_PER_CYC;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, mlt, acc_n, prod;
  logic [WIDTH-1:0] mb, ua, ub;
  logic [CW-1:0] cnt;
  logic neg, sgn, last, accept;
  assign busy = state == RUN;
  assign done = state == FIX;
  // operand magnitudes, next partial sum and sign-corrected final product
  always_comb begin
    sgn    = is_signed & (SIGNED_EN != 0);
    ua     = (sgn && a[WIDTH-1]) ? -a : a;
    ub     = (sgn && b[WIDTH-1]) ? -b : b;
    acc_n  = acc + mlt * {{(2*WIDTH-BITS_PER_CYC){1'b0}}, mb[BITS_PER_CYC-1:0]};
    prod   = neg ? -acc_n : acc_n;
    last   = cnt == CW'(N-1);
    accept = start & ~flush & ~busy;
  end
  // next-state: flush always returns to IDLE; done cycle may accept a new op
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == RUN) state_n = last ? FIX : RUN;
    else state_n = accept ? RUN : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // datapath: multiplicand shifts left while multiplier slices retire LSB-first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mlt <= '0;
      mb  <= '0;
      cnt <= '0;
      neg <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else if (accept) begin
      acc <= '0;
      mlt <= {{WIDTH{1'b0}}, ua};
      mb  <= ub;
      cnt <= '0;
      neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == RUN && !flush) begin
      acc <= acc_n;
      mlt <= mlt << BITS_PER_CYC;
      mb  <= mb >> BITS_PER_CYC;
      cnt <= cnt + CW'(1);
      if (last) {hi, lo} <= prod;
    end
  end
endmodule
